// File: rtl/i2c_gyro_responder.sv
// i2c_gyro_responder
//   I2C target that emulates the MPU-6050 register interface, so the gyro I2C
//   master can be exercised in simulation or in board loopback without the
//   physical sensor. Reads are served from a gyro snapshot latched at every
//   START (including repeated START), which keeps each burst read coherent.
//
// Ports
//   clk_in         system clock, at least 16x the SCL frequency
//   rst_in         asynchronous active-high reset
//   scl_in/sda_in  raw bus levels (asynchronous to clk_in)
//   sda_oe_out     1 = pull SDA low, 0 = release
//   gx/gy/gz_in    live gyro samples, two's complement
//   pwr_mgmt_out   PWR_MGMT_1 (0x6B) contents
//   wr_strobe_out  one-cycle pulse per accepted register write
//   wr_addr_out    register address of the last accepted write
//   busy_out       high from an addressed START until STOP
module i2c_gyro_responder #(
  parameter logic [6:0] DEV_ADDR = 7'h68,
  parameter logic [7:0] WHO_AM_I = 8'h68,
  parameter logic [7:0] PWR_RST  = 8'h40
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               scl_in,
  input  logic               sda_in,
  output logic               sda_oe_out,
  input  logic signed [15:0] gx_in,
  input  logic signed [15:0] gy_in,
  input  logic signed [15:0] gz_in,
  output logic [7:0]         pwr_mgmt_out,
  output logic               wr_strobe_out,
  output logic [7:0]         wr_addr_out,
  output logic               busy_out
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  bit_cnt, cnt_nxt;
  logic [7:0]  ptr, ptr_nxt;
  logic        oe_nxt, busy_nxt, strobe_nxt;
  logic [7:0]  pwr_nxt, wr_addr_nxt;
  logic [7:0]  shreg;
  logic [47:0] snap;

  // Synchronizer stages: _p0/_p1 are the 2-FF synchronizer, _p2 is the
  // previous synchronized level used for edge detection.
  logic scl_p0, scl_p1, scl_p2;
  logic sda_p0, sda_p1, sda_p2;

  logic scl_rise, scl_fall, start_det, stop_det;
  logic byte_done, cnt_state, shift_state, addr_hit;
  logic [2:0] rd_idx;
  logic [7:0] rd_cur, rd_next;

  function automatic logic [7:0] reg_read(input logic [7:0]  a,
                                          input logic [47:0] s,
                                          input logic [7:0]  pwr);
    case (a)
      8'h43:   reg_read = s[47:40];
      8'h44:   reg_read = s[39:32];
      8'h45:   reg_read = s[31:24];
      8'h46:   reg_read = s[23:16];
      8'h47:   reg_read = s[15:8];
      8'h48:   reg_read = s[7:0];
      8'h6B:   reg_read = pwr;
      8'h75:   reg_read = WHO_AM_I;
      default: reg_read = 8'h00;
    endcase
  endfunction

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      scl_p0 <= 1'b1; scl_p1 <= 1'b1; scl_p2 <= 1'b1;
      sda_p0 <= 1'b1; sda_p1 <= 1'b1; sda_p2 <= 1'b1;
    end else begin
      scl_p0 <= scl_in; scl_p1 <= scl_p0; scl_p2 <= scl_p1;
      sda_p0 <= sda_in; sda_p1 <= sda_p0; sda_p2 <= sda_p1;
    end
  end

  assign scl_rise  = scl_p1 & ~scl_p2;
  assign scl_fall  = ~scl_p1 & scl_p2;
  assign start_det = scl_p1 & scl_p2 & sda_p2 & ~sda_p1;
  assign stop_det  = scl_p1 & scl_p2 & ~sda_p2 & sda_p1;

  assign byte_done   = (bit_cnt == 4'd8);
  assign cnt_state   = state inside {ADDR, PTR, WR_DATA, RD_DATA};
  assign shift_state = state inside {ADDR, PTR, WR_DATA};
  assign addr_hit    = (shreg[7:1] == DEV_ADDR);
  assign rd_idx      = 3'd7 - bit_cnt[2:0];
  assign rd_cur      = reg_read(ptr, snap, pwr_mgmt_out);
  assign rd_next     = reg_read(ptr + 8'd1, snap, pwr_mgmt_out);

  // State and control registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state         <= IDLE;
      bit_cnt       <= 4'd0;
      ptr           <= 8'h00;
      sda_oe_out    <= 1'b0;
      pwr_mgmt_out  <= PWR_RST;
      wr_strobe_out <= 1'b0;
      wr_addr_out   <= 8'h00;
      busy_out      <= 1'b0;
    end else begin
      state         <= state_nxt;
      bit_cnt       <= cnt_nxt;
      ptr           <= ptr_nxt;
      sda_oe_out    <= oe_nxt;
      pwr_mgmt_out  <= pwr_nxt;
      wr_strobe_out <= strobe_nxt;
      wr_addr_out   <= wr_addr_nxt;
      busy_out      <= busy_nxt;
    end
  end

  // Data registers: received byte and START-time gyro snapshot
  always_ff @(posedge clk_in) begin
    if (scl_rise && shift_state) shreg <= {shreg[6:0], sda_p1};
    if (start_det) snap <= {gx_in, gy_in, gz_in};
  end

  // Byte phases advance on SCL falling edges so SDA only ever moves while
  // SCL is low; the ACK slot of each byte starts at the fall after bit 8.
  always_comb begin
    state_nxt = state;
    if (start_det) begin
      state_nxt = ADDR;
    end else if (stop_det) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:     state_nxt = IDLE;
        ADDR:     if (scl_fall && byte_done) state_nxt = addr_hit ? ADDR_ACK : IDLE;
        ADDR_ACK: if (scl_fall) state_nxt = shreg[0] ? RD_DATA : PTR;
        PTR:      if (scl_fall && byte_done) state_nxt = PTR_ACK;
        PTR_ACK:  if (scl_fall) state_nxt = WR_DATA;
        WR_DATA:  if (scl_fall && byte_done) state_nxt = WR_ACK;
        WR_ACK:   if (scl_fall) state_nxt = WR_DATA;
        RD_DATA:  if (scl_fall && byte_done) state_nxt = RD_ACK;
        RD_ACK: begin
          if (scl_rise && sda_p1) state_nxt = IDLE;
          else if (scl_fall)      state_nxt = RD_DATA;
        end
        default:  state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_nxt     = bit_cnt;
    ptr_nxt     = ptr;
    oe_nxt      = sda_oe_out;
    pwr_nxt     = pwr_mgmt_out;
    strobe_nxt  = 1'b0;
    wr_addr_nxt = wr_addr_out;
    busy_nxt    = busy_out;
    if (start_det) begin
      cnt_nxt = 4'd0;
      oe_nxt  = 1'b0;
    end else if (stop_det) begin
      cnt_nxt  = 4'd0;
      oe_nxt   = 1'b0;
      busy_nxt = 1'b0;
    end else begin
      if (scl_rise && cnt_state) cnt_nxt = bit_cnt + 4'd1;
      case (state)
        ADDR: if (scl_fall && byte_done) begin
          cnt_nxt = 4'd0;
          oe_nxt  = addr_hit;
          if (addr_hit) busy_nxt = 1'b1;
        end
        // A read starts driving its first bit in the same fall that ends the ACK
        ADDR_ACK: if (scl_fall) oe_nxt = shreg[0] ? ~rd_cur[7] : 1'b0;
        PTR: if (scl_fall && byte_done) begin
          cnt_nxt = 4'd0;
          ptr_nxt = shreg;
          oe_nxt  = 1'b1;
        end
        PTR_ACK: if (scl_fall) oe_nxt = 1'b0;
        WR_DATA: if (scl_fall && byte_done) begin
          cnt_nxt     = 4'd0;
          oe_nxt      = 1'b1;
          strobe_nxt  = 1'b1;
          wr_addr_nxt = ptr;
          if (ptr == 8'h6B) pwr_nxt = shreg;
          ptr_nxt     = ptr + 8'd1;
        end
        WR_ACK: if (scl_fall) oe_nxt = 1'b0;
        RD_DATA: if (scl_fall) begin
          if (byte_done) begin
            cnt_nxt = 4'd0;
            oe_nxt  = 1'b0;
          end else begin
            oe_nxt = ~rd_cur[rd_idx];
          end
        end
        // Only reached on a fall after the master ACKed; a NACK leaves on the rise
        RD_ACK: if (scl_fall) begin
          ptr_nxt = ptr + 8'd1;
          oe_nxt  = ~rd_next[7];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_gyro_responder.sv
module tb_i2c_gyro_responder;

  localparam int H = 10;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        scl_in;
  logic        sda_m;
  logic        sda_line;
  logic        sda_oe_out;
  logic signed [15:0] gx, gy, gz;
  logic [7:0]  pwr_mgmt_out;
  logic        wr_strobe_out;
  logic [7:0]  wr_addr_out;
  logic        busy_out;

  always #5 clk_in = ~clk_in;
  assign sda_line = sda_m & ~sda_oe_out;

  i2c_gyro_responder dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .scl_in        (scl_in),
    .sda_in        (sda_line),
    .sda_oe_out    (sda_oe_out),
    .gx_in         (gx),
    .gy_in         (gy),
    .gz_in         (gz),
    .pwr_mgmt_out  (pwr_mgmt_out),
    .wr_strobe_out (wr_strobe_out),
    .wr_addr_out   (wr_addr_out),
    .busy_out      (busy_out)
  );

  // Reference model of the register-level behaviour
  logic [7:0]  m_ptr;
  logic [7:0]  exp_pwr;
  logic [7:0]  exp_wr_addr;
  logic        exp_busy;
  logic [47:0] m_snap;
  int          exp_strobes = 0;
  int          strobe_cnt  = 0;
  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  rd_log[$];
  event        chk_ev;

  localparam int K_ADDR = 0, K_PTR = 1, K_DATA = 2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_reg(input logic [7:0] a);
    case (a)
      8'h43:   return m_snap[47:40];
      8'h44:   return m_snap[39:32];
      8'h45:   return m_snap[31:24];
      8'h46:   return m_snap[23:16];
      8'h47:   return m_snap[15:8];
      8'h48:   return m_snap[7:0];
      8'h6B:   return exp_pwr;
      8'h75:   return 8'h68;
      default: return 8'h00;
    endcase
  endfunction

  always @(negedge clk_in) if (wr_strobe_out === 1'b1) strobe_cnt++;

  always begin
    @(chk_ev);
    chk("pwr_mgmt", {24'd0, pwr_mgmt_out}, {24'd0, exp_pwr});
    chk("busy", {31'd0, busy_out}, {31'd0, exp_busy});
    chk("wr_addr", {24'd0, wr_addr_out}, {24'd0, exp_wr_addr});
    chk("strobe_count", strobe_cnt, exp_strobes);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic bit_xfer(input logic b, output logic r);
    scl_in = 1'b0; wait_clk(H/2);
    sda_m  = b;    wait_clk(H/2);
    scl_in = 1'b1; wait_clk(H/2);
    r = sda_line;
    -> chk_ev;
    wait_clk(H/2);
  endtask

  task automatic i2c_start();
    scl_in = 1'b0; wait_clk(H/2);
    sda_m  = 1'b1; wait_clk(H/2);
    scl_in = 1'b1; wait_clk(H/2);
    sda_m  = 1'b0;
    m_snap = {gx, gy, gz};
    wait_clk(H/2);
  endtask

  task automatic i2c_stop();
    scl_in = 1'b0; wait_clk(H/2);
    sda_m  = 1'b0; wait_clk(H/2);
    scl_in = 1'b1; wait_clk(H/2);
    sda_m  = 1'b1; wait_clk(H);
    exp_busy = 1'b0;
    -> chk_ev;
    chk("oe_after_stop", {31'd0, sda_oe_out}, 32'd0);
    wait_clk(H/2);
  endtask

  task automatic send_byte(input logic [7:0] d, input int kind, output logic nack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], r);
    if (kind == K_ADDR) begin
      if (d[7:1] == 7'h68) exp_busy = 1'b1;
    end else if (kind == K_PTR) begin
      m_ptr = d;
    end else begin
      if (m_ptr == 8'h6B) exp_pwr = d;
      exp_wr_addr = m_ptr;
      exp_strobes++;
      m_ptr = m_ptr + 8'd1;
    end
    bit_xfer(1'b1, nack);
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic nack);
    logic r;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bit_xfer(1'b1, r);
      d = {d[6:0], r};
    end
    bit_xfer(nack, r);
  endtask

  task automatic set_ptr(input logic [7:0] p);
    logic a;
    i2c_start();
    send_byte(8'hD0, K_ADDR, a); chk("ack_addr_w", {31'd0, a}, 32'd0);
    send_byte(p, K_PTR, a);      chk("ack_ptr", {31'd0, a}, 32'd0);
  endtask

  task automatic write_data(input logic [7:0] d);
    logic a;
    send_byte(d, K_DATA, a); chk("ack_data", {31'd0, a}, 32'd0);
  endtask

  // START + read address + n bytes, last one NACKed
  task automatic read_burst(input int n, input bit perturb);
    logic a;
    logic [7:0] d, e;
    i2c_start();
    send_byte(8'hD1, K_ADDR, a); chk("ack_addr_r", {31'd0, a}, 32'd0);
    rd_log.delete();
    for (int i = 0; i < n; i++) begin
      e = model_reg(m_ptr);
      recv_byte(d, (i == n - 1));
      chk("rd_byte", {24'd0, d}, {24'd0, e});
      rd_log.push_back(d);
      if (i != n - 1) m_ptr = m_ptr + 8'd1;
      if (perturb && i == 1) begin
        gx = 16'($urandom); gy = 16'($urandom); gz = 16'($urandom);
      end
    end
  endtask

  function automatic logic [7:0] pick_ptr();
    case ($urandom_range(0, 9))
      0: return 8'h43;
      1: return 8'h44;
      2: return 8'h45;
      3: return 8'h47;
      4: return 8'h6B;
      5: return 8'h75;
      6: return 8'hFF;
      7: return 8'h6A;
      8: return 8'h00;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    logic a, got;
    logic [7:0]  p;
    logic [6:0]  ad;
    logic [47:0] lit;
    int s0, n, op;

    rst_in = 1'b1; scl_in = 1'b1; sda_m = 1'b1;
    gx = 16'sd0; gy = 16'sd0; gz = 16'sd0;
    m_ptr = 8'h00; exp_pwr = 8'h40; exp_wr_addr = 8'h00; exp_busy = 1'b0; m_snap = 48'd0;
    wait_clk(5);
    chk("rst_oe", {31'd0, sda_oe_out}, 32'd0);
    chk("rst_pwr", {24'd0, pwr_mgmt_out}, 32'h40);
    chk("rst_strobe", {31'd0, wr_strobe_out}, 32'd0);
    chk("rst_wr_addr", {24'd0, wr_addr_out}, 32'd0);
    chk("rst_busy", {31'd0, busy_out}, 32'd0);
    rst_in = 1'b0;
    wait_clk(5);

    // WHO_AM_I via repeated START
    set_ptr(8'h75);
    read_burst(1, 1'b0);
    chk("who_am_i_lit", {24'd0, rd_log[0]}, 32'h68);
    i2c_stop();

    // Coherent six-byte burst with the live sample changing mid-burst
    gx = 16'sh1234; gy = -16'sh0124; gz = 16'sh0F0F;
    set_ptr(8'h43);
    read_burst(6, 1'b1);
    lit = 48'h1234_FEDC_0F0F;
    for (int i = 0; i < 6; i++)
      chk("burst_lit", {24'd0, rd_log[i]}, {24'd0, lit[47 - 8*i -: 8]});
    i2c_stop();

    // Writable PWR_MGMT_1 and a discarded write elsewhere
    s0 = strobe_cnt;
    set_ptr(8'h6B); write_data(8'h00); i2c_stop();
    chk("pwr_lit", {24'd0, pwr_mgmt_out}, 32'h00);
    chk("wr_addr_lit", {24'd0, wr_addr_out}, 32'h6B);
    chk("one_strobe", strobe_cnt - s0, 1);
    set_ptr(8'h10); write_data(8'h5A); i2c_stop();
    chk("wr_addr_lit2", {24'd0, wr_addr_out}, 32'h10);
    chk("pwr_kept_lit", {24'd0, pwr_mgmt_out}, 32'h00);

    // Foreign address
    i2c_start();
    send_byte(8'hD2, K_ADDR, a);
    chk("nack_foreign", {31'd0, a}, 32'd1);
    chk("busy_foreign", {31'd0, busy_out}, 32'd0);
    i2c_stop();

    // Pointer wrap
    set_ptr(8'hFF);
    read_burst(2, 1'b0);
    chk("wrap_lit0", {24'd0, rd_log[0]}, 32'h00);
    chk("wrap_lit1", {24'd0, rd_log[1]}, 32'h00);
    i2c_stop();

    // STOP after four data bits of a write
    s0 = strobe_cnt;
    set_ptr(8'h6B);
    bit_xfer(1'b1, a); bit_xfer(1'b0, a); bit_xfer(1'b1, a); bit_xfer(1'b0, a);
    i2c_stop();
    chk("partial_no_strobe", strobe_cnt - s0, 0);
    chk("partial_pwr_lit", {24'd0, pwr_mgmt_out}, 32'h00);

    // Reset while the target drives a 0 bit of PWR_MGMT_1 (currently 0x00)
    set_ptr(8'h6B);
    i2c_start();
    send_byte(8'hD1, K_ADDR, a); chk("ack_addr_rst", {31'd0, a}, 32'd0);
    scl_in = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk_in);
      if (sda_oe_out === 1'b1) got = 1'b1;
    end
    chk("rd_drive_timeout", {31'd0, got}, 32'd1);
    rst_in = 1'b1;
    #1;
    chk("async_rst_oe", {31'd0, sda_oe_out}, 32'd0);
    chk("async_rst_pwr", {24'd0, pwr_mgmt_out}, 32'h40);
    chk("async_rst_busy", {31'd0, busy_out}, 32'd0);
    exp_pwr = 8'h40; m_ptr = 8'h00; exp_busy = 1'b0; exp_wr_addr = 8'h00;
    wait_clk(4);
    rst_in = 1'b0;
    wait_clk(4);
    i2c_stop();
    set_ptr(8'h6B);
    read_burst(1, 1'b0);
    chk("pwr_after_rst_lit", {24'd0, rd_log[0]}, 32'h40);
    i2c_stop();

    // Randomized transactions
    for (int t = 0; t < 24; t++) begin
      gx = 16'($urandom); gy = 16'($urandom); gz = 16'($urandom);
      op = $urandom_range(0, 3);
      n  = $urandom_range(1, 4);
      case (op)
        0: begin
          set_ptr(pick_ptr());
          for (int i = 0; i < n - 1; i++) write_data(8'($urandom));
          i2c_stop();
        end
        1: begin
          set_ptr(pick_ptr());
          read_burst(n, 1'($urandom_range(0, 1)));
          i2c_stop();
        end
        2: begin
          read_burst(n, 1'b0);
          i2c_stop();
        end
        default: begin
          ad = 7'($urandom_range(0, 127));
          if (ad == 7'h68) ad = 7'h69;
          p = {ad, 1'($urandom_range(0, 1))};
          i2c_start();
          send_byte(p, K_ADDR, a);
          chk("nack_rand", {31'd0, a}, 32'd1);
          i2c_stop();
        end
      endcase
    end

    wait_clk(10);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
